// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one SRAM controller between the
// MEM stage (port 0) and a second bus master (port 1). The granted command is
// registered toward the controller with byte addresses translated into the
// controller's halfword address space; per-port ready mirrors the controller.
module sram_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_R_EN,
    input  logic        p0_W_EN,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_R_EN,
    input  logic        p1_W_EN,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic        ctl_R_EN,
    output logic        ctl_W_EN,
    output logic [31:0] ctl_addr,
    output logic [31:0] ctl_wdata,
    input  logic [31:0] ctl_rdata,
    input  logic        ctl_Ready,
    output logic        busy,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t      state_reg;
    logic        last_reg;      // port that owned the most recent completed access
    logic        ctl_r_en_reg;
    logic        ctl_w_en_reg;
    logic [31:0] ctl_addr_reg;
    logic [31:0] ctl_wdata_reg;
    logic        busy_reg;
    logic [1:0]  grant_reg;

    // Per-port views so the ready/rdata logic can be generated uniformly.
    logic [1:0]  req;
    logic [1:0]  own;
    logic [1:0]  ready_vec;
    logic [31:0] rdata_arr [2];

    // Selected requester's command.
    logic        win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] sel_xlat;

    assign req = {p1_R_EN | p1_W_EN, p0_R_EN | p0_W_EN};
    assign own = {state_reg == BUSY1, state_reg == BUSY0};

    // Winner: a sole requester wins; on a tie the port that did not go last wins.
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last_reg;
        end
    end

    // A request with both enables set is treated as a write.
    assign sel_we    = win ? p1_W_EN  : p0_W_EN;
    assign sel_addr  = win ? p1_addr  : p0_addr;
    assign sel_wdata = win ? p1_wdata : p0_wdata;
    // Byte address relative to the data-memory base, expressed in halfwords.
    assign sel_xlat  = (sel_addr - BASE_ADDR) >> 1;

    // Arbitration FSM: grant in IDLE, hold the command until the controller completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            ctl_r_en_reg  <= 1'b0;
            ctl_w_en_reg  <= 1'b0;
            ctl_addr_reg  <= 32'd0;
            ctl_wdata_reg <= 32'd0;
            busy_reg      <= 1'b0;
            grant_reg     <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg     <= win ? BUSY1 : BUSY0;
                        ctl_w_en_reg  <= sel_we;
                        ctl_r_en_reg  <= ~sel_we;
                        ctl_addr_reg  <= sel_xlat;
                        ctl_wdata_reg <= sel_wdata;
                        busy_reg      <= 1'b1;
                        grant_reg     <= win ? 2'b10 : 2'b01;
                    end
                end
                BUSY0, BUSY1: begin
                    if (ctl_Ready) begin
                        state_reg    <= IDLE;
                        ctl_r_en_reg <= 1'b0;
                        ctl_w_en_reg <= 1'b0;
                        last_reg     <= (state_reg == BUSY1);
                        busy_reg     <= 1'b0;
                        grant_reg    <= 2'b00;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Ready is high for an idle port, or for the owner in the controller's final cycle;
    // read data is only passed to the port that owns the controller.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi] = ~req[gi] | (own[gi] & ctl_Ready);
            assign rdata_arr[gi] = own[gi] ? ctl_rdata : 32'd0;
        end
    endgenerate

    assign p0_ready  = ready_vec[0];
    assign p1_ready  = ready_vec[1];
    assign p0_rdata  = rdata_arr[0];
    assign p1_rdata  = rdata_arr[1];

    assign ctl_R_EN  = ctl_r_en_reg;
    assign ctl_W_EN  = ctl_w_en_reg;
    assign ctl_addr  = ctl_addr_reg;
    assign ctl_wdata = ctl_wdata_reg;
    assign busy      = busy_reg;
    assign grant     = grant_reg;

endmodule
